// File: rtl/prng_arb_pkg.sv
// Shared types and default constants for the PRNG request arbiter.
// Contents: FSM state encoding, default LFSR seed and Galois feedback taps.
package prng_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    ACK  = 2'd2
  } prng_arb_state_e;

  // Defaults for a 32-bit maximal-length Galois LFSR.
  localparam logic [31:0] DefaultSeed   = 32'h0000_0001;
  localparam logic [31:0] DefaultCoeffs = 32'h8000_0057;

endpackage

// File: rtl/prng_rr_arbiter.sv
// Combinational round-robin pick: returns the first asserted request index
// strictly after 'last', searching upward with wrap-around.
// Ports:
//   req       in   NumReq  request levels
//   last      in   IdxW    index that won the previous arbitration
//   gnt_idx   out  IdxW    winning index (0 when gnt_valid is low)
//   gnt_valid out  1       any request asserted
module prng_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_valid
);

  // Scan offsets 1..NumReq so 'last' itself is considered only after all others.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = (32'(last) + off) % NumReq;
      if (!gnt_valid && req[IdxW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/prng_req_arbiter.sv
// Shared pseudo-random number server: one Galois LFSR, advanced Steps times per
// grant, handing a fresh word to round-robin-selected requesters.
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous active-high reset
//   req_i        in   NumReq  request levels, held until ack
//   ack_o        out  NumReq  one-hot single-cycle ack; data_o valid with it
//   data_o       out  OutDw   random word, held until the next grant
//   seed_valid_i in   1       reseed request
//   seed_i       in   LfsrDw  reseed value (zero selects Seed)
//   seed_ready_o out  1       reseed accepted when high with seed_valid_i
//   busy_o       out  1       FSM is not idle
module prng_req_arbiter
  import prng_arb_pkg::*;
#(
  parameter int unsigned        NumReq = 4,
  parameter int unsigned        LfsrDw = 32,
  parameter int unsigned        OutDw  = 16,
  parameter int unsigned        Steps  = 4,
  parameter logic [LfsrDw-1:0]  Seed   = LfsrDw'(DefaultSeed),
  parameter logic [LfsrDw-1:0]  Coeffs = LfsrDw'(DefaultCoeffs)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] ack_o,
  output logic [OutDw-1:0]  data_o,
  input  logic              seed_valid_i,
  input  logic [LfsrDw-1:0] seed_i,
  output logic              seed_ready_o,
  output logic              busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(Steps + 1);

  prng_arb_state_e     state_q, state_d;
  logic [LfsrDw-1:0]   lfsr_q, lfsr_d, lfsr_adv;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     gnt_q, gnt_d, last_q, last_d;
  logic [OutDw-1:0]    data_q, data_d;
  logic [NumReq-1:0]   ack_q, ack_d;
  logic                ready_q, ready_d, busy_q, busy_d;
  logic [IdxW-1:0]     rr_idx;
  logic                rr_valid;

  prng_rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr (
    .req       (req_i),
    .last      (last_q),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // One Galois step; an all-zero result would lock the LFSR, so recover to Seed.
  always_comb begin
    lfsr_adv = (lfsr_q >> 1) ^ ({LfsrDw{lfsr_q[0]}} & Coeffs);
    if (lfsr_adv == '0) begin
      lfsr_adv = Seed;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    data_d  = data_q;
    ack_d   = '0;

    unique case (state_q)
      IDLE: begin
        // Reseed wins over requests; requests are arbitrated next cycle.
        if (seed_valid_i) begin
          lfsr_d = (seed_i == '0) ? Seed : seed_i;
        end else if (rr_valid) begin
          gnt_d   = rr_idx;
          cnt_d   = CntW'(Steps);
          state_d = STEP;
        end
      end
      STEP: begin
        lfsr_d = lfsr_adv;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          data_d  = lfsr_adv[OutDw-1:0];
          state_d = ACK;
          // Ack is registered, so it is qualified by the request one cycle early.
          if (req_i[gnt_q]) begin
            ack_d[gnt_q] = 1'b1;
          end
        end
      end
      ACK: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lfsr_q  <= Seed;
      cnt_q   <= '0;
      gnt_q   <= '0;
      last_q  <= IdxW'(NumReq - 1);
      data_q  <= '0;
      ack_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_o        = ack_q;
  assign data_o       = data_q;
  assign seed_ready_o = ready_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_prng_req_arbiter.sv
// Scoreboard bench for prng_req_arbiter: a transaction-level model predicts
// each grant's ack and word; a negedge monitor compares whatever the DUT shows.
module tb_prng_req_arbiter;

  localparam int unsigned NumReq = 4;
  localparam int unsigned LfsrDw = 32;
  localparam int unsigned OutDw  = 16;
  localparam int unsigned Steps  = 4;
  localparam logic [31:0] SEED   = 32'h0000_0001;
  localparam logic [31:0] COEFFS = 32'h8000_0057;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [15:0] data;
  logic        seed_valid;
  logic [31:0] seed;
  logic        seed_ready;
  logic        busy;

  prng_req_arbiter #(
    .NumReq (NumReq),
    .LfsrDw (LfsrDw),
    .OutDw  (OutDw),
    .Steps  (Steps),
    .Seed   (SEED),
    .Coeffs (COEFFS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .ack_o        (ack),
    .data_o       (data),
    .seed_valid_i (seed_valid),
    .seed_i       (seed),
    .seed_ready_o (seed_ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int cyc; logic [3:0] ack; logic [15:0] data;} ack_exp_t;
  typedef struct {int cyc; logic busy; logic ready;} st_exp_t;

  ack_exp_t ack_q[$];
  st_exp_t  st_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_on = 0;

  // Reference model state (transaction level)
  logic [31:0] m_lfsr;
  int          m_last;
  int          next_free;
  bit          pend_v;
  int          pend_final;
  int          pend_idx;
  logic [15:0] pend_data;
  int          lock_until [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] q);
    logic [31:0] n;
    n = (q >> 1) ^ (q[0] ? COEFFS : 32'h0);
    return (n == 32'h0) ? SEED : n;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++) begin
      int i;
      i = (last + off) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Predict DUT behaviour for the inputs applied in the current cycle.
  task automatic model_eval(input logic do_rst);
    bit busy_e;
    int p;
    if (do_rst) begin
      while (ack_q.size() > 0 && ack_q[$].cyc >= cyc) void'(ack_q.pop_back());
      st_q.push_back('{cyc, 1'b0, 1'b1});
      m_lfsr    = SEED;
      m_last    = 3;
      next_free = cyc + 1;
      pend_v    = 0;
      return;
    end
    busy_e = (cyc < next_free);
    st_q.push_back('{cyc, busy_e, !busy_e});
    if (pend_v && cyc == pend_final) begin
      ack_q.push_back('{cyc + 1, req[pend_idx] ? 4'(1 << pend_idx) : 4'b0, pend_data});
      pend_v = 0;
    end
    if (!busy_e) begin
      if (seed_valid) begin
        m_lfsr = (seed == 32'h0) ? SEED : seed;
      end else begin
        p = rr_pick(req, m_last);
        if (p >= 0) begin
          for (int s = 0; s < int'(Steps); s++) m_lfsr = lstep(m_lfsr);
          pend_data  = m_lfsr[15:0];
          pend_idx   = p;
          pend_final = cyc + int'(Steps);
          pend_v     = 1;
          next_free  = cyc + int'(Steps) + 2;
          m_last     = p;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply(input logic [3:0] r, input logic sv, input logic [31:0] sd, input logic dr);
    req        = r;
    seed_valid = sv;
    seed       = sd;
    rst        = dr;
    model_eval(dr);
  endtask

  task automatic run_cycle(input logic [3:0] r, input logic sv, input logic [31:0] sd, input logic dr);
    tick();
    apply(r, sv, sd, dr);
  endtask

  // Random requester behaviour: hold until acked, occasional drop mid-grant.
  task automatic rand_cycle();
    logic [3:0]  r;
    logic        sv;
    logic [31:0] sd;
    logic        dr;
    logic [3:0]  ack_now;
    tick();
    ack_now = 4'b0;
    foreach (ack_q[k]) if (ack_q[k].cyc == cyc) ack_now = ack_q[k].ack;
    r = req;
    for (int i = 0; i < 4; i++) begin
      if (cyc < lock_until[i]) begin
        r[i] = 1'b0;
      end else if (r[i]) begin
        if (pend_v && pend_idx == i && cyc <= pend_final && $urandom_range(0, 9) == 0) begin
          r[i] = 1'b0;
          lock_until[i] = pend_final + 1;
        end else if (ack_now[i] && $urandom_range(0, 1) == 0) begin
          r[i] = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        r[i] = 1'b1;
      end
    end
    sv = ($urandom_range(0, 15) == 0);
    sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    dr = ($urandom_range(0, 299) == 0);
    apply(r, sv, sd, dr);
  endtask

  // Monitor: compares DUT outputs with whatever the model predicted for this cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      while (st_q.size() > 0 && st_q[0].cyc < cyc) void'(st_q.pop_front());
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        st_exp_t s;
        s = st_q.pop_front();
        check("busy", 32'(busy), 32'(s.busy));
        check("seed_ready", 32'(seed_ready), 32'(s.ready));
      end
      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        ack_exp_t e;
        e = ack_q.pop_front();
        check("ack", 32'(ack), 32'(e.ack));
        if (e.ack != 4'b0) check("data", 32'(data), 32'(e.data));
      end else begin
        check("ack_idle", 32'(ack), 32'h0);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req        = 4'b0;
    seed_valid = 1'b0;
    seed       = 32'h0;
    foreach (lock_until[i]) lock_until[i] = 0;

    run_cycle(4'b0, 1'b0, 32'h0, 1'b1);
    mon_on = 1;
    run_cycle(4'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(4'b0, 1'b0, 32'h0, 1'b0);
    #2;
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_data", 32'(data), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_ready", 32'(seed_ready), 32'h1);

    // Single requester 0 from reset: word 16'h001F five cycles later.
    repeat (5) run_cycle(4'b0001, 1'b0, 32'h0, 1'b0);
    run_cycle(4'b0000, 1'b0, 32'h0, 1'b0);
    #2;
    check("first_ack", 32'(ack), 32'h1);
    check("first_data", 32'(data), 32'h001F);
    repeat (2) run_cycle(4'b0, 1'b0, 32'h0, 1'b0);

    // Three requesters from reset: order 0, 1, 3 spaced Steps+2.
    run_cycle(4'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(4'b0, 1'b0, 32'h0, 1'b0);
    repeat (18) run_cycle(4'b1011, 1'b0, 32'h0, 1'b0);
    repeat (3) run_cycle(4'b0, 1'b0, 32'h0, 1'b0);

    // Zero reseed together with req 2: seed first, grant next cycle.
    run_cycle(4'b0100, 1'b1, 32'h0, 1'b0);
    repeat (5) run_cycle(4'b0100, 1'b0, 32'h0, 1'b0);
    run_cycle(4'b0000, 1'b0, 32'h0, 1'b0);
    #2;
    check("reseed_ack", 32'(ack), 32'h4);
    check("reseed_data", 32'(data), 32'h001F);
    repeat (2) run_cycle(4'b0, 1'b0, 32'h0, 1'b0);

    // Requester 1 drops during STEP: no ack, then 2 beats 1.
    run_cycle(4'b0010, 1'b0, 32'h0, 1'b0);
    repeat (6) run_cycle(4'b0000, 1'b0, 32'h0, 1'b0);
    repeat (14) run_cycle(4'b0110, 1'b0, 32'h0, 1'b0);
    repeat (3) run_cycle(4'b0, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of STEP aborts the grant.
    repeat (2) run_cycle(4'b0001, 1'b0, 32'h0, 1'b0);
    run_cycle(4'b0001, 1'b0, 32'h0, 1'b1);
    run_cycle(4'b0000, 1'b0, 32'h0, 1'b0);
    repeat (5) run_cycle(4'b0001, 1'b0, 32'h0, 1'b0);
    run_cycle(4'b0000, 1'b0, 32'h0, 1'b0);
    #2;
    check("post_reset_data", 32'(data), 32'h001F);
    repeat (2) run_cycle(4'b0, 1'b0, 32'h0, 1'b0);

    // Reseed held across a grant is only taken once back in IDLE.
    repeat (2) run_cycle(4'b0001, 1'b0, 32'h0, 1'b0);
    repeat (3) run_cycle(4'b0001, 1'b1, 32'hDEAD_BEEF, 1'b0);
    repeat (2) run_cycle(4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0);
    repeat (6) run_cycle(4'b0001, 1'b0, 32'h0, 1'b0);
    repeat (3) run_cycle(4'b0, 1'b0, 32'h0, 1'b0);

    repeat (3000) rand_cycle();

    repeat (10) run_cycle(4'b0, 1'b0, 32'h0, 1'b0);
    check("drain", 32'(ack_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prng_req_arbiter.md
# prng_req_arbiter

Shared pseudo-random number server that sequences a single Galois XOR LFSR and distributes its output among `NumReq` requesters with round-robin fairness. On each grant the block advances the LFSR a fixed number of steps, then returns a fresh word to the winner. This decorrelates consecutive consumers. The block sits between the entropy/seed source and masking or jitter consumers (e.g. cipher cores, randomized timers), so the LFSR datapath is never free-running or shared unsafely.

## Interface
- `NumReq`, default 4: number of requesters, ≥2.
- `LfsrDw`, default 32: LFSR state width.
- `OutDw`, default 16: returned word width, ≤`LfsrDw`.
- `Steps`, default 4: LFSR advances per grant, ≥1.
- `Seed`, default 32'h1: reset and lockup-recovery state, nonzero.
- `Coeffs`, default 32'h80000057: Galois feedback taps.
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  NumReq  per-requester request level, held until ack.
- `ack_o`  out  NumReq  one-hot, one-cycle pulse; `data_o` is valid in this cycle.
- `data_o`  out  OutDw  registered random word, held until the next grant.
- `seed_valid_i`  in  1  reseed request.
- `seed_i`  in  LfsrDw  reseed value.
- `seed_ready_o`  out  1  reseed accepted in the cycle where `seed_valid_i && seed_ready_o`.
- `busy_o`  out  1  FSM is not IDLE.

## Operation
- LFSR step: `q_next = (q >> 1) ^ ({LfsrDw{q[0]}} & Coeffs)`. The register changes only in STEP or on reseed.
- FSM states: IDLE, STEP, ACK.
- IDLE:
  - `seed_ready_o`=1.
  - If `seed_valid_i`, load `seed_i` into the LFSR; if `seed_i`==0, load `Seed` instead. Stay in IDLE.
  - Reseed has priority over requests in the same cycle. Requests wait one cycle.
  - Otherwise, if `|req_i`, the round-robin arbiter picks the first asserted index after `last_q`, searching upward with wrap. Latch it as `gnt_q`, load `step_cnt`=`Steps`, go to STEP.
- STEP:
  - Advance the LFSR once per cycle and decrement `step_cnt`.
  - When `step_cnt`==1, latch `data_o` from the post-step state bits `[OutDw-1:0]` and go to ACK.
  - `seed_valid_i` is ignored (`seed_ready_o`=0).
- ACK:
  - If `req_i[gnt_q]` is still high, `ack_o[gnt_q]`=1. Otherwise the grant is silently dropped and no ack is issued.
  - In both cases set `last_q`=`gnt_q` and return to IDLE.
- Lockup: if a step would produce all-zero state, load `Seed` instead. This is unreachable with nonzero state and correct taps, but it is mandatory.
- `busy_o` = (state != IDLE).

## Timing
- Reset values:
  - FSM = IDLE, LFSR = `Seed`, `last_q` = NumReq-1 (so index 0 wins first).
  - `ack_o`=0, `data_o`=0, `busy_o`=0, `seed_ready_o`=1.
- Latency:
  - A request seen in IDLE at cycle t gives STEP in cycles t+1..t+Steps and `ack_o` in cycle t+Steps+1.
  - Next arbitration happens at t+Steps+2, so there is one grant per Steps+2 cycles.
- `ack_o` is a registered decode of the ACK state and `gnt_q`, gated by `req_i`. It is never multi-hot and never lasts more than one cycle.
- A requester that keeps `req_i` high after its ack is re-arbitrated and can win again only after all other active requesters are served.
- Reset asserted mid-STEP or mid-ACK aborts immediately: no ack, and the LFSR returns to `Seed`.

## Structure
- Package `prng_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, STEP, ACK} prng_arb_state_e`.
  - Default `Coeffs`/`Seed` constants.
- Sub-module `prng_rr_arbiter`: combinational round-robin pick. Inputs are `req`, `last`, `NumReq`; outputs are `gnt_idx` and `gnt_valid`. It is reused by other shared-resource controllers.
- LFSR register, step counter and FSM stay in the top module.

## Test plan
- Reset, then `req_i`=4'b0001 held. Required response: `ack_o[0]` at cycle t+5, `data_o`=16'h001F (state 32'h3000001F after 4 steps from 1).
- `req_i`=4'b1011 held for 3 grants. Required response: acks in order 0, 1, 3, each spaced 6 cycles.
- `seed_valid_i` and `req_i[2]` in the same IDLE cycle with `seed_i`=0. Required response: LFSR=`Seed`, then grant to 2 one cycle later with the same `data_o` as the first scenario.
- `req_i[1]` dropped during STEP. Required response: no `ack_o`, return to IDLE, and `last_q`=1 (next contender 2 wins before 1).
- `rst_i` pulsed during STEP. Required response: no `ack_o`, `busy_o`=0, and the next grant returns 16'h001F.
- `seed_valid_i` during STEP. Required response: `seed_ready_o`=0 and the seed is not loaded until IDLE.
